stream_demultiplexer: RTL and testbench

- Inverse of the select-driven 3:1 multiplexer: one input stream fans out to one of NOUT output channels, chosen by a per-beat select.
- Valid/ready handshake on both sides.
- Output is registered in a single-entry holding register.
- Out-of-range selects are dropped and flagged, not left undefined.
- Sits between a single producer and up to NOUT consumers in the test designs.

---
 rtl/stream_demux_pkg.sv | 15 +
 rtl/stream_demultiplexer_onehot_decoder.sv | 23 ++
 rtl/stream_demultiplexer.sv | 95 +++++++++
 tb/tb_stream_demultiplexer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream demultiplexer.
// Optional drop counter is enabled by STREAM_DEMUX_DROP_COUNT_EN.
package stream_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DW_DEF     = 1;
  localparam int NOUT_DEF   = 3;
  localparam int SW_DEF     = 2;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/stream_demultiplexer_onehot_decoder.sv
// Select-to-one-hot decoder with enable and out-of-range flag.
// Both outputs are forced low when en is low.
module onehot_decoder #(
  parameter int SW   = 2,
  parameter int NOUT = 3
) (
  input  logic [SW-1:0]   sel,
  input  logic            en,
  output logic [NOUT-1:0] onehot,
  output logic            oor
);

  // Extra bit keeps the compare correct when 2**SW == NOUT.
  assign oor = en & ({1'b0, sel} >= (SW+1)'(NOUT));

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NOUT; k++) begin
      onehot[k] = en & (sel == SW'(k));
    end
  end

endmodule

// File: rtl/stream_demultiplexer.sv
// One-to-NOUT stream demux with a single registered holding slot.
// Define STREAM_DEMUX_DROP_COUNT_EN to add the drop_cnt port.
module stream_demultiplexer
  import stream_demux_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NOUT = NOUT_DEF,
  parameter int SW   = SW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SW-1:0]   in_sel,
  output logic [NOUT-1:0] out_valid,
  input  logic [NOUT-1:0] out_ready,
  output logic [DW-1:0]   out_data,
  output logic            err
`ifdef STREAM_DEMUX_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  state_t          state, state_nx;
  logic [SW-1:0]   cur_sel, cur_sel_nx;
  logic [DW-1:0]   data_q, data_nx;
  logic            err_nx;
  logic            accept;
  logic            drain;
  logic            drop;
  logic            load;
  logic [NOUT-1:0] in_hot;
  logic            held_oor_unused;

  onehot_decoder #(.SW(SW), .NOUT(NOUT)) u_out_dec (
    .sel    (cur_sel),
    .en     (state == FULL),
    .onehot (out_valid),
    .oor    (held_oor_unused)
  );

  onehot_decoder #(.SW(SW), .NOUT(NOUT)) u_in_dec (
    .sel    (in_sel),
    .en     (accept),
    .onehot (in_hot),
    .oor    (drop)
  );

  assign drain    = |(out_valid & out_ready);
  assign in_ready = (state == EMPTY) | drain;
  assign accept   = in_valid & in_ready;
  assign load     = |in_hot;
  assign out_data = data_q;

  always_comb begin
    state_nx   = state;
    cur_sel_nx = cur_sel;
    data_nx    = data_q;
    err_nx     = drop;
    if (load) begin
      state_nx   = FULL;
      cur_sel_nx = in_sel;
      data_nx    = in_data;
    end else if (drain) begin
      state_nx = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      cur_sel <= '0;
      data_q  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cur_sel <= cur_sel_nx;
      data_q  <= data_nx;
      err     <= err_nx;
    end
  end

`ifdef STREAM_DEMUX_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed self-checking bench for stream_demultiplexer.
// Drop-counter checks run only with STREAM_DEMUX_DROP_COUNT_EN.
module tb_stream_demultiplexer;
  import stream_demux_pkg::*;

  localparam int DW   = 1;
  localparam int NOUT = 3;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic [NOUT-1:0] out_valid;
  logic [NOUT-1:0] out_ready;
  logic [DW-1:0]   out_data;
  logic            err;
`ifdef STREAM_DEMUX_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demultiplexer #(.DW(DW), .NOUT(NOUT), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sel = '0;
    out_ready = '0;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1 || err !== 1'b0
        || out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b rdy=%b err=%b data=%b want 000 1 0 0",
               out_valid, in_ready, err, out_data);
    end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    cyc();
    out_ready = 3'b000;
    in_valid = 1'b1;
    in_sel = 2'd2;
    in_data = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b100 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: valid=%b rdy=%b want 100 0",
               out_valid, in_ready);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b rdy=%b err=%b want 000 1 0",
               out_valid, in_ready, err);
    end
  endtask

  task automatic test_routing();
    cyc();
    out_ready = 3'b111;
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL route_lat: valid=%b want 000", out_valid);
    end
    cyc();
    in_sel = 2'd2;
    in_data = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b001 || out_data !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL route0: valid=%b data=%b rdy=%b want 001 0 1",
               out_valid, out_data, in_ready);
    end
    cyc();
    in_sel = 2'd1;
    in_data = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b100 || out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL route2: valid=%b data=%b want 100 0",
               out_valid, out_data);
    end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b010 || out_data !== 1'b1) begin
      n_fail++;
      $display("FAIL route1: valid=%b data=%b want 010 1",
               out_valid, out_data);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL route_empty: valid=%b rdy=%b want 000 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_invalid_sel();
    cyc();
    in_valid = 1'b1;
    in_sel = 2'd3;
    in_data = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL drop_err: err=%b valid=%b want 1 000", err, out_valid);
    end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_cnt1: got %0d want 1", drop_cnt);
    end
`endif
    cyc();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || out_valid !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_after: err=%b valid=%b rdy=%b want 0 000 1",
               err, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    cyc();
    out_ready = 3'b000;
    in_valid = 1'b1;
    in_sel = 2'd1;
    in_data = 1'b1;
    cyc();
    in_sel = 2'd0;
    in_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 3'b010 || out_data !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%b rdy=%b want 010 1 0",
                 i, out_valid, out_data, in_ready);
      end
      cyc();
    end
    out_ready = 3'b010;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b001 || out_data !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_reload: valid=%b data=%b rdy=%b want 001 0 0",
               out_valid, out_data, in_ready);
    end
    out_ready = 3'b001;
    cyc();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b want 000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [NOUT-1:0] exp_v;
    logic            exp_d;
    cyc();
    out_ready = 3'b011;
    in_valid = 1'b1;
    exp_v = 3'b000;
    exp_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_sel = SW'(i % 2);
      in_data = DW'((i >> 1) & 1);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== exp_v
          || (i > 0 && out_data !== exp_d)) begin
        n_fail++;
        $display("FAIL b2b%0d: rdy=%b valid=%b data=%b want 1 %b %b",
                 i, in_ready, out_valid, out_data, exp_v, exp_d);
      end
      exp_v = (i % 2 == 0) ? 3'b001 : 3'b010;
      exp_d = ((i >> 1) & 1) != 0;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== exp_v || out_data !== exp_d) begin
      n_fail++;
      $display("FAIL b2b_last: valid=%b data=%b want %b %b",
               out_valid, out_data, exp_v, exp_d);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_empty: valid=%b want 000", out_valid);
    end
  endtask

`ifdef STREAM_DEMUX_DROP_COUNT_EN
  task automatic test_saturation();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_err%0d: err=%b want 1", i, err);
        end
      end
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 8'd255 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_cnt: cnt=%0d err=%b want 255 1", drop_cnt, err);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 8'd255 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%0d err=%b want 255 0", drop_cnt, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_routing();
    test_invalid_sel();
    test_backpressure();
    test_back_to_back();
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
